// File: rtl/dds_pkg.sv
// dds_pkg: shared sizing constants for the voice mixer
package dds_pkg;
  localparam int M        = 12;
  localparam int VOICES   = 4;
  localparam int MIDSCALE = 1 << (M - 1);
  localparam int ATTEN_W  = 2;
endpackage

// File: rtl/dsm1.sv
// dsm1: first-order delta-sigma modulator; one density tracks din/2^M
module dsm1
  import dds_pkg::*;
#(
  parameter int M = dds_pkg::M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [M-1:0] mix_out,
  output logic         dsm_out
);
  logic [M:0]   sum;
  logic [M-1:0] acc_d, acc_q;
  logic         dsm_d, dsm_q;
  // accumulate while enabled; the carry is the output bit, forced low when idle
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, mix_out};
    acc_d = ena ? sum[M-1:0] : acc_q;
    dsm_d = ena & sum[M];
  end
  // accumulator and output bit registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      dsm_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      dsm_q <= dsm_d;
    end
  end
  assign dsm_out = dsm_q;
endmodule

// File: rtl/voice_mixer.sv
// voice_mixer: 3-stage attenuate/sum/saturate mixer with sticky clip and delta-sigma output
module voice_mixer
  import dds_pkg::*;
#(
  parameter int M      = dds_pkg::M,
  parameter int VOICES = dds_pkg::VOICES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic [VOICES*M-1:0]         samples,
  input  logic                        sample_valid,
  input  logic [VOICES-1:0]           voice_en,
  input  logic [ATTEN_W*VOICES-1:0]   atten,
  input  logic                        clip_clr,
  output logic [M-1:0]                mix_out,
  output logic                        mix_valid,
  output logic                        dsm_out,
  output logic                        clip
);
  localparam logic signed [M+1:0] MAXV = (M+2)'((1 << (M - 1)) - 1);
  localparam logic signed [M+1:0] MINV = ~MAXV;
  localparam logic [M-1:0]        MID  = {1'b1, {(M-1){1'b0}}};
  logic signed [M-1:0] tc  [VOICES];
  logic signed [M-1:0] v_d [VOICES];
  logic signed [M-1:0] v_q [VOICES];
  logic signed [M+1:0] sum_d, sum_q;
  logic [M-1:0]        mix_d, mix_q;
  logic                v1_q, v2_q, mix_valid_q, clip_d, clip_q, sat_hi, sat_lo;
  // stage 1 input: offset-binary to two's complement, attenuate, mask disabled voices
  always_comb begin
    for (int i = 0; i < VOICES; i++) begin
      tc[i]  = $signed({~samples[i*M+M-1], samples[i*M +: M-1]}) >>> atten[ATTEN_W*i +: ATTEN_W];
      v_d[i] = voice_en[i] ? tc[i] : '0;
    end
  end
  // stage 2 input: wide signed sum so VOICES full-scale voices cannot overflow
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < VOICES; i++) sum_d = sum_d + (M+2)'(v_q[i]);
  end
  // stage 3 input: saturate to M bits, back to offset-binary; clip set beats clear
  always_comb begin
    sat_hi = sum_q > MAXV;
    sat_lo = sum_q < MINV;
    mix_d  = sat_hi ? '1 : sat_lo ? '0 : {~sum_q[M-1], sum_q[M-2:0]};
    clip_d = ena ? ((v2_q & (sat_hi | sat_lo)) | (clip_q & ~clip_clr)) : clip_q;
  end
  // pipeline registers; everything holds while ena is low, mix_valid drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q         <= '{default: '0};
      sum_q       <= '0;
      mix_q       <= MID;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      mix_valid_q <= 1'b0;
      clip_q      <= 1'b0;
    end else begin
      if (ena) begin
        if (sample_valid) v_q <= v_d;
        v1_q  <= sample_valid;
        sum_q <= sum_d;
        v2_q  <= v1_q;
        if (v2_q) mix_q <= mix_d;
      end
      mix_valid_q <= ena & v2_q;
      clip_q      <= clip_d;
    end
  end
  assign mix_out   = mix_q;
  assign mix_valid = mix_valid_q;
  assign clip      = clip_q;
  dsm1 #(.M(M)) u_dsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .mix_out (mix_q),
    .dsm_out (dsm_out)
  );
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: directed self-checking bench for voice_mixer
module tb_voice_mixer;
  logic        clk = 1'b0;
  logic        rst_n, ena, sample_valid, clip_clr;
  logic [47:0] samples;
  logic [3:0]  voice_en;
  logic [7:0]  atten;
  logic [11:0] mix_out;
  logic        mix_valid, dsm_out, clip;
  int          total = 0;
  int          passed = 0;
  int          ones;

  voice_mixer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .samples      (samples),
    .sample_valid (sample_valid),
    .voice_en     (voice_en),
    .atten        (atten),
    .clip_clr     (clip_clr),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .dsm_out      (dsm_out),
    .clip         (clip)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] pk(input logic [11:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
  endtask

  task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %03h expected %03h", tag, obs, exp);
  endtask

  // present one sample, return at the negedge where its result is visible
  task automatic send(input logic [47:0] s, input logic [3:0] en, input logic [7:0] at, input logic clr);
    samples = s; voice_en = en; atten = at; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk1("lat1_valid", mix_valid, 1'b0);
    @(negedge clk);
    chk1("lat2_valid", mix_valid, 1'b0);
    clip_clr = clr;
    @(negedge clk);
    chk1("lat3_valid", mix_valid, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; sample_valid = 1'b0; clip_clr = 1'b0;
    samples = pk(12'h800, 12'h800, 12'h800, 12'h800); voice_en = 4'h0; atten = 8'h00;
    repeat (2) @(negedge clk);
    chk12("rst_mix", mix_out, 12'h800);
    chk1("rst_valid", mix_valid, 1'b0);
    chk1("rst_dsm", dsm_out, 1'b0);
    chk1("rst_clip", clip, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("dsm_mid_alt", dsm_out, k[0]);
    end

    send(pk(12'hC00, 12'h400, 12'hFFF, 12'hFFF), 4'b0011, 8'h00, 1'b0);
    chk12("cancel_mix", mix_out, 12'h800);
    chk1("cancel_clip", clip, 1'b0);

    send(pk(12'hC00, 12'hFFF, 12'hFFF, 12'hFFF), 4'b0001, 8'h02, 1'b0);
    chk12("atten2_mix", mix_out, 12'h900);

    send(pk(12'h000, 12'hFFF, 12'h900, 12'h7FF), 4'b1111, 8'h07, 1'b0);
    chk12("mixed_atten", mix_out, 12'hBFE);
    chk1("mixed_clip", clip, 1'b0);

    send(pk(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF), 4'b1111, 8'h00, 1'b0);
    chk12("sat_hi_mix", mix_out, 12'hFFF);
    chk1("sat_hi_clip", clip, 1'b1);
    @(negedge clk);
    chk1("post_valid", mix_valid, 1'b0);
    chk12("hold_mix", mix_out, 12'hFFF);
    chk1("clip_sticky", clip, 1'b1);
    clip_clr = 1'b1;
    @(negedge clk);
    clip_clr = 1'b0;
    chk1("clip_cleared", clip, 1'b0);

    send(pk(12'h000, 12'h000, 12'h000, 12'h000), 4'b1111, 8'h00, 1'b0);
    chk12("sat_lo_mix", mix_out, 12'h000);
    chk1("sat_lo_clip", clip, 1'b1);
    clip_clr = 1'b1;
    @(negedge clk);
    clip_clr = 1'b0;
    chk1("clip_cleared2", clip, 1'b0);

    send(pk(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF), 4'b1111, 8'h00, 1'b1);
    chk1("set_wins", clip, 1'b1);
    @(negedge clk);
    clip_clr = 1'b0;
    chk1("clr_alone", clip, 1'b0);

    samples = pk(12'h900, 12'h0, 12'h0, 12'h0); voice_en = 4'b0001; atten = 8'h00; sample_valid = 1'b1;
    @(negedge clk);
    samples = pk(12'hA00, 12'h0, 12'h0, 12'h0);
    @(negedge clk);
    samples = pk(12'h700, 12'h0, 12'h0, 12'h0);
    @(negedge clk);
    sample_valid = 1'b0;
    chk1("b2b_v0", mix_valid, 1'b1);
    chk12("b2b_m0", mix_out, 12'h900);
    @(negedge clk);
    chk1("b2b_v1", mix_valid, 1'b1);
    chk12("b2b_m1", mix_out, 12'hA00);
    @(negedge clk);
    chk1("b2b_v2", mix_valid, 1'b1);
    chk12("b2b_m2", mix_out, 12'h700);
    @(negedge clk);
    chk1("b2b_end", mix_valid, 1'b0);
    chk12("b2b_hold", mix_out, 12'h700);

    samples = pk(12'hA00, 12'h0, 12'h0, 12'h0); sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0; ena = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk1("ena0_valid", mix_valid, 1'b0);
      chk1("ena0_dsm", dsm_out, 1'b0);
      chk12("ena0_mix", mix_out, 12'h700);
    end
    ena = 1'b1;
    @(negedge clk);
    chk1("ena1_wait", mix_valid, 1'b0);
    @(negedge clk);
    chk1("ena1_valid", mix_valid, 1'b1);
    chk12("ena1_mix", mix_out, 12'hA00);

    send(pk(12'hC00, 12'h0, 12'h0, 12'h0), 4'b0001, 8'h00, 1'b0);
    chk12("dens_mix", mix_out, 12'hC00);
    ones = 0;
    repeat (1024) begin
      @(negedge clk);
      ones += int'(dsm_out);
    end
    chk12("dsm_density", 12'(ones), 12'd768);

    samples = pk(12'h100, 12'h0, 12'h0, 12'h0); voice_en = 4'b0001; sample_valid = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk12("midrst_mix", mix_out, 12'h800);
    chk1("midrst_dsm", dsm_out, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; sample_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk1("flush_valid", mix_valid, 1'b0);
      chk12("flush_mix", mix_out, 12'h800);
    end
    chk1("flush_clip", clip, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
